// File: rtl/countdown_timer_bcd.sv
// Two-digit BCD countdown timer driven by an internal prescaler of clk_in.
// Loads a clamped 00-99 preset, counts down one step per TICK_DIV cycles
// once started, pulses done on reaching 00 and holds there until load/reset.
module countdown_timer_bcd #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] preset_tens,
    input  logic [3:0] preset_units,
    input  logic       start,
    input  logic       pause,
    output logic [7:0] out,
    output logic       running,
    output logic       done,
    output logic       expired
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_tens;
    logic [3:0]    r_units;
    logic [3:0]    w_tens_nxt;
    logic [3:0]    w_units_nxt;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_nxt;
    logic          r_done;
    logic          w_done_nxt;
    logic          w_zero;
    logic          w_last_step;

    // Digits above 9 are not valid BCD; saturate them to 9.
    function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    assign w_zero      = (r_tens == 4'd0) && (r_units == 4'd0);
    assign w_last_step = (r_tens == 4'd0) && (r_units == 4'd1);

    // State, count, prescaler and done pulse registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_tens  <= '0;
            r_units <= '0;
            r_presc <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tens  <= w_tens_nxt;
            r_units <= w_units_nxt;
            r_presc <= w_presc_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic: load > pause > start/tick.
    // Leaving PAUSED with pause low advances the prescaler on that same edge,
    // so each paused cycle delays the following ticks by exactly one edge.
    always_comb begin
        w_state_nxt = r_state;
        w_tens_nxt  = r_tens;
        w_units_nxt = r_units;
        w_presc_nxt = r_presc;
        w_done_nxt  = 1'b0;

        if (load) begin
            w_tens_nxt  = clamp_bcd(preset_tens);
            w_units_nxt = clamp_bcd(preset_units);
            w_presc_nxt = '0;
            w_state_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start && !w_zero) begin
                        w_state_nxt = S_RUN;
                        w_presc_nxt = '0;
                    end
                end
                S_RUN, S_PAUSED: begin
                    if (pause) begin
                        w_state_nxt = S_PAUSED;
                    end else begin
                        w_state_nxt = S_RUN;
                        if (r_presc == PRESC_LAST) begin
                            w_presc_nxt = '0;
                            if (!w_zero) begin
                                if (r_units != 4'd0) begin
                                    w_units_nxt = r_units - 4'd1;
                                end else begin
                                    w_units_nxt = 4'd9;
                                    w_tens_nxt  = r_tens - 4'd1;
                                end
                                if (w_last_step) begin
                                    w_state_nxt = S_DONE;
                                    w_done_nxt  = 1'b1;
                                end
                            end
                        end else begin
                            w_presc_nxt = r_presc + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign out     = {r_tens, r_units};
    assign running = (r_state == S_RUN);
    assign expired = (r_state == S_DONE);
    assign done    = r_done;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Self-checking bench for countdown_timer_bcd with TICK_DIV = 4.
module tb_countdown_timer_bcd;

    localparam int TD = 4;

    logic       clk_in = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [3:0] preset_tens = 4'd0;
    logic [3:0] preset_units = 4'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] out;
    logic       running;
    logic       done;
    logic       expired;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: decimal count, edges remaining until the next tick.
    int m_count = 0;
    int m_left = TD;
    int m_mode = 0;     // 0 idle, 1 run, 2 paused, 3 done
    bit m_done = 1'b0;

    countdown_timer_bcd #(.TICK_DIV(TD)) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .load        (load),
        .preset_tens (preset_tens),
        .preset_units(preset_units),
        .start       (start),
        .pause       (pause),
        .out         (out),
        .running     (running),
        .done        (done),
        .expired     (expired)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic       r;
        logic       l;
        logic [3:0] pt;
        logic [3:0] pu;
        logic       s;
        logic       p;
        logic [7:0] e_out;
        logic       e_run;
        logic       e_done;
        logic       e_exp;
    } vec_t;

    task automatic model_edge(input logic r, input logic l, input logic [3:0] pt,
                              input logic [3:0] pu, input logic s, input logic p);
        int t;
        int u;
        m_done = 1'b0;
        if (!r) begin
            m_count = 0;
            m_mode  = 0;
            m_left  = TD;
        end else if (l) begin
            t = (pt > 9) ? 9 : int'(pt);
            u = (pu > 9) ? 9 : int'(pu);
            m_count = t * 10 + u;
            m_mode  = 0;
            m_left  = TD;
        end else begin
            case (m_mode)
                0: if (s && m_count != 0) begin
                    m_mode = 1;
                    m_left = TD;
                end
                1, 2: if (p) begin
                    m_mode = 2;
                end else begin
                    m_mode = 1;
                    m_left--;
                    if (m_left == 0) begin
                        m_left = TD;
                        m_count--;
                        if (m_count == 0) begin
                            m_mode = 3;
                            m_done = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Apply one cycle of inputs, clock it, advance the model, sample #1 later.
    task automatic cyc(input logic r, input logic l, input logic [3:0] pt,
                       input logic [3:0] pu, input logic s, input logic p);
        rst_n = r; load = l; preset_tens = pt; preset_units = pu;
        start = s; pause = p;
        @(posedge clk_in);
        model_edge(r, l, pt, pu, s, p);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic chk_model(input string nm);
        logic [7:0] e;
        e = {4'(m_count / 10), 4'(m_count % 10)};
        chk({nm, ".out"}, out, e);
        chk({nm, ".running"}, {7'd0, running}, {7'd0, m_mode == 1});
        chk({nm, ".done"}, {7'd0, done}, {7'd0, m_done});
        chk({nm, ".expired"}, {7'd0, expired}, {7'd0, m_mode == 3});
    endtask

    task automatic chk_all(input string nm, input logic [7:0] e_out, input logic e_run,
                           input logic e_done, input logic e_exp);
        chk({nm, ".out"}, out, e_out);
        chk({nm, ".running"}, {7'd0, running}, {7'd0, e_run});
        chk({nm, ".done"}, {7'd0, done}, {7'd0, e_done});
        chk({nm, ".expired"}, {7'd0, expired}, {7'd0, e_exp});
    endtask

    initial begin
        vec_t vt[$];
        int done_seen;

        // Borrow, expiry, restart-after-done, load/clamp/priority vectors.
        vt.push_back('{0,0,0,0,0,0, 8'h00,0,0,0});
        vt.push_back('{0,0,0,0,0,0, 8'h00,0,0,0});
        vt.push_back('{1,1,2,1,0,0, 8'h21,0,0,0});
        vt.push_back('{1,0,0,0,1,0, 8'h21,1,0,0});   // E0
        vt.push_back('{1,0,0,0,0,0, 8'h21,1,0,0});
        vt.push_back('{1,0,0,0,0,0, 8'h21,1,0,0});
        vt.push_back('{1,0,0,0,0,0, 8'h21,1,0,0});
        vt.push_back('{1,0,0,0,0,0, 8'h20,1,0,0});   // E0+4
        vt.push_back('{1,0,0,0,0,0, 8'h20,1,0,0});
        vt.push_back('{1,0,0,0,0,0, 8'h20,1,0,0});
        vt.push_back('{1,0,0,0,0,0, 8'h20,1,0,0});
        vt.push_back('{1,0,0,0,0,0, 8'h19,1,0,0});   // E0+8 borrow
        vt.push_back('{1,1,0,2,0,0, 8'h02,0,0,0});
        vt.push_back('{1,0,0,0,1,0, 8'h02,1,0,0});   // E0
        vt.push_back('{1,0,0,0,0,0, 8'h02,1,0,0});
        vt.push_back('{1,0,0,0,0,0, 8'h02,1,0,0});
        vt.push_back('{1,0,0,0,0,0, 8'h02,1,0,0});
        vt.push_back('{1,0,0,0,0,0, 8'h01,1,0,0});   // E0+4
        vt.push_back('{1,0,0,0,0,0, 8'h01,1,0,0});
        vt.push_back('{1,0,0,0,0,0, 8'h01,1,0,0});
        vt.push_back('{1,0,0,0,0,0, 8'h01,1,0,0});
        vt.push_back('{1,0,0,0,0,0, 8'h00,0,1,1});   // E0+8 expiry
        vt.push_back('{1,0,0,0,0,0, 8'h00,0,0,1});
        vt.push_back('{1,0,0,0,1,1, 8'h00,0,0,1});   // start/pause ignored in DONE
        vt.push_back('{1,0,0,0,1,0, 8'h00,0,0,1});
        vt.push_back('{1,1,0,5,0,0, 8'h05,0,0,0});
        vt.push_back('{1,1,15,12,0,0, 8'h99,0,0,0}); // clamp
        vt.push_back('{1,1,4,2,1,0, 8'h42,0,0,0});   // load beats start
        vt.push_back('{1,0,0,0,0,0, 8'h42,0,0,0});
        vt.push_back('{1,1,0,0,0,0, 8'h00,0,0,0});
        vt.push_back('{1,0,0,0,1,0, 8'h00,0,0,0});   // start at 00 ignored
        vt.push_back('{1,0,0,0,0,0, 8'h00,0,0,0});

        // Reset with random inputs held for two edges.
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
        end
        chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 0, 0);
        chk_all("post_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vt.size(); i++) begin
            cyc(vt[i].r, vt[i].l, vt[i].pt, vt[i].pu, vt[i].s, vt[i].p);
            chk_all($sformatf("vec%0d", i), vt[i].e_out, vt[i].e_run, vt[i].e_done, vt[i].e_exp);
        end

        // Pause: 5 paused edges starting at E0+3 push the first tick to E0+9.
        cyc(1, 1, 0, 3, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);                      // E0
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0, 0, 0, 1);
            chk_all($sformatf("paused%0d", i), 8'h03, 1'b0, 1'b0, 1'b0);
        end
        cyc(1, 0, 0, 0, 0, 0);                      // E0+8
        chk_all("resume", 8'h03, 1'b1, 1'b0, 1'b0);
        cyc(1, 0, 0, 0, 0, 0);                      // E0+9
        chk_all("first_tick_after_pause", 8'h02, 1'b1, 1'b0, 1'b0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1);                      // terminal prescaler cycle
        chk_all("pause_on_terminal", 8'h02, 1'b0, 1'b0, 1'b0);
        cyc(1, 0, 0, 0, 0, 0);
        chk_all("tick_after_terminal_pause", 8'h01, 1'b1, 1'b0, 1'b0);

        // Load mid-run returns to IDLE and stops the countdown.
        cyc(1, 1, 5, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 0, 0);
        chk_all("mid_run", 8'h49, 1'b1, 1'b0, 1'b0);
        cyc(1, 1, 4, 2, 0, 0);
        chk_all("load_mid_run", 8'h42, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0, 0);
        chk_all("load_mid_run_hold", 8'h42, 1'b0, 1'b0, 1'b0);

        // Reset mid-run from a clamped 99 preset: no done pulse.
        cyc(1, 1, 12, 15, 0, 0);
        chk_all("clamp99", 8'h99, 1'b0, 1'b0, 1'b0);
        cyc(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 0);
        chk_all("run99", 8'h98, 1'b1, 1'b0, 1'b0);
        cyc(0, 0, 0, 0, 0, 0);
        chk_all("reset_mid_run", 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(1, 0, 0, 0, 0, 0);
        chk_all("after_reset_mid_run", 8'h00, 1'b0, 1'b0, 1'b0);

        // Randomized traffic against the reference model.
        done_seen = 0;
        for (int i = 0; i < 4000; i++) begin
            logic r;
            logic l;
            logic s;
            logic p;
            r = ($urandom_range(0, 299) != 0);
            l = ($urandom_range(0, 59) == 0);
            s = ($urandom_range(0, 5) == 0);
            p = ($urandom_range(0, 6) == 0);
            cyc(r, l, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)), s, p);
            chk_model($sformatf("rand%0d", i));
            if (m_done) done_seen++;
        end
        chk("rand_done_coverage", 8'(done_seen > 0), 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/countdown_timer_bcd.md
# countdown_timer_bcd

Two-digit BCD countdown timer: the down-counting counterpart of the 1 Hz up-counting BCD LED counter. Loads a 00–99 preset and, once started, decrements one count per tick from an internal prescaler of the 50 MHz board clock. On reaching 00 it pulses `done` and holds. `out[7:0]` drives the same LED bank as the up-counter: tens on [7:4], units on [3:0].

## Interface
- `TICK_DIV`, default 50_000_000: clk_in cycles per decrement, 1 Hz at 50 MHz. Legal range is ≥2. Benches use 4.
- `clk_in` input 1: the only clock, the 50 MHz board clock (CLK_50M at top level).
- `rst_n` input 1: reset, synchronous and active-low.
- `load` input 1: copies the preset digits into the count and forces IDLE.
- `preset_tens` input 4: BCD tens digit of the preset.
- `preset_units` input 4: BCD units digit of the preset.
- `start` input 1: begins the countdown from IDLE.
- `pause` input 1: level-sensitive; freezes the countdown while high.
- `out` output 8: current count, {tens, units}, BCD.
- `running` output 1: high in RUN only.
- `done` output 1: one-cycle pulse when the count reaches 00.
- `expired` output 1: high in DONE.

## Operation
- States:
  - IDLE: count held; waiting for start.
  - RUN: prescaler advancing.
  - PAUSED: count and prescaler frozen.
  - DONE: count = 00.
- All inputs are sampled on the rising edge of clk_in.
- Priority is rst_n low > load > pause > start / tick.
- Reset: on any edge with rst_n=0, regardless of state:
  - out = 8'h00, prescaler = 0, state = IDLE.
  - running = 0, done = 0, expired = 0.
- load, accepted in any state:
  - out = {clamp(preset_tens), clamp(preset_units)}; a digit >9 is clamped to 9.
  - prescaler = 0, state = IDLE.
  - A start in the same cycle is ignored.
- IDLE:
  - start=1 with out≠00 → RUN, prescaler = 0.
  - start=1 with out=00 → ignored; stay IDLE.
  - pause has no effect.
- RUN:
  - pause=1 → PAUSED; prescaler and count hold. pause wins even on the terminal prescaler cycle.
  - Otherwise the prescaler increments. When it equals TICK_DIV−1, it wraps to 0 and the count decrements.
- Decrement rules:
  - units≠0 → units−1.
  - units=0 → units = 9, tens = tens−1.
  - Count 00 is never decremented.
- Terminal count: if the decrement yields 00, the same edge sets state = DONE, done = 1 and expired = 1.
- PAUSED:
  - pause=0 → RUN; the prescaler resumes from its held value. Remaining cycles to the next tick are preserved.
  - start is ignored.
- DONE:
  - Holds out = 00 and expired = 1.
  - start and pause are ignored. Only load or reset leaves DONE.
- done is high for exactly one cycle per expiry. It is never asserted by load or reset.
- Prescaler width is $clog2(TICK_DIV). It never exceeds TICK_DIV−1.

## Timing
- All outputs are registered, with no combinational input→output paths.
- load accepted at edge E → out shows the preset after E. Load-to-output latency is 1 cycle.
- start accepted at edge E0:
  - running = 1 after E0.
  - First decrement occurs at edge E0+TICK_DIV, then every TICK_DIV edges while not paused.
- Each cycle pause is high in RUN or PAUSED shifts all subsequent ticks by one edge.
- Preset N (decimal), no pause: out reaches 00 at edge E0+N·TICK_DIV.
  - done is high in the cycle after that edge only.
  - running falls at the same edge.
- Reset asserted mid-run takes effect at that edge; no done pulse is produced.

## Test plan
- **Reset:** hold rst_n=0 for 2 edges with random inputs → out=8'h00; running, done and expired all 0. Release, then apply no start → out stays 8'h00 for 20 cycles.
- **Borrow (TICK_DIV=4):** load 2/1, start at E0.
  - out=8'h21 until E0+4, then 8'h20.
  - At E0+8 → 8'h19, showing the units wrap to 9 with tens borrow.
  - running=1 throughout.
- **Expiry:** load 0/2, start at E0.
  - 8'h01 at E0+4; 8'h00 at E0+8.
  - done=1 for exactly one cycle, expired=1, running=0.
  - A later start leaves out=8'h00 with no second done.
  - A later load 0/5 returns to IDLE with out=8'h05.
- **Pause:** load 0/3, start, pause high for 5 cycles starting 2 cycles after start.
  - out holds 8'h03 and running=0 while paused.
  - First decrement lands at E0+4+5.
  - pause high on a terminal prescaler cycle → no decrement that edge.
- **Load priority:**
  - load 4/2 mid-run → IDLE, out=8'h42, no further decrements.
  - load and start in the same cycle → IDLE, no countdown.
  - start with out=8'h00 in IDLE → stays IDLE.
- **Clamp and reset:**
  - load F/C → out=8'h99.
  - start, then assert rst_n=0 mid-run → out=8'h00 at the next edge, no done pulse.
